vga_sync: RTL and testbench
===========================

# vga_sync

Raster timing generator for the Pong display path. It divides the system clock down to the pixel rate and runs horizontal and vertical counters over the full 800x525 raster. It drives the monitor's `hsync`/`vsync` pins, and feeds `video_on`, `x` and `y` to the pixel generator, which returns the 12-bit colour for that coordinate. It also supplies line and frame strobes that the game logic uses to advance ball and paddle state once per frame.

## Interface
- `CLK_DIV`, 4: system clocks per pixel. Range 2..16; a 100 MHz system clock gives a 25 MHz pixel clock.
- `H_DISPLAY`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal timing in pixels.
- `V_DISPLAY`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical timing in lines.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `p_tick` out 1: pixel strobe, high for one `clk` cycle every `CLK_DIV` cycles.
- `x` out 10: horizontal counter, range 0..H_TOTAL-1 (H_TOTAL = 800).
- `y` out 10: vertical counter, range 0..V_TOTAL-1 (V_TOTAL = 525).
- `hsync` out 1: horizontal sync, active-low.
- `vsync` out 1: vertical sync, active-low.
- `video_on` out 1: high while x < H_DISPLAY and y < V_DISPLAY.
- `line_end` out 1: one-`clk` pulse marking the last pixel of a line.
- `frame_end` out 1: one-`clk` pulse marking the last pixel of a frame.
- `frame_cnt` out 16: frame counter (see Configuration).

## Operation
- **Divider.** Counter `div` runs 0..CLK_DIV-1 and wraps to 0. `p_tick = (div == CLK_DIV-1)`.
- **Horizontal counter.** On a clock edge with `p_tick` high, `x` increments. When x == H_TOTAL-1 it wraps to 0.
- **Vertical counter.** `y` increments only on the `p_tick` edge where x wraps. When y == V_TOTAL-1 it wraps to 0.
- **Counters hold between ticks.** `x` and `y` change only on `p_tick` edges.
- **Sync outputs.** Both are registered. Each register loads the value decoded from the *next* counter value, so the sync edges are cycle-aligned with `x`/`y`:
  - `hsync` = 0 exactly when x is in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1], i.e. [656, 751].
  - `vsync` = 0 exactly when y is in [490, 491].
- **Strobes.**
  - `video_on` is combinational from `x` and `y`.
  - `line_end = p_tick & (x == H_TOTAL-1)`.
  - `frame_end = line_end & (y == V_TOTAL-1)`.
- **Widths.** All comparisons are 10-bit unsigned. Every porch and total constant is derived from the parameters; no literal totals are used.
- **Reset (asserted mid-frame).** All of the following take effect immediately, with no waiting for a tick:
  - `div`, `x`, `y` = 0
  - `hsync` = 1, `vsync` = 1
  - `frame_cnt` = 0
  - `p_tick`, `line_end`, `frame_end` = 0
  - `video_on` = 1 (the counters are at 0,0)

## Timing
- **After reset release.** The first `p_tick` occurs on the 4th `clk` edge (div = 3). Counters read (1,0) after that edge.
- **Line and frame periods.** One line is H_TOTAL × CLK_DIV = 3200 clks. One frame is 525 × 3200 = 1,680,000 clks.
- **Strobe coincidence.** `line_end` and `frame_end` assert in the same cycle as the final `p_tick` of the line or frame. Consumers sample them on that edge.
- **Pixel generator latency.** It samples `x`, `y` and `video_on` combinationally, so its RGB output is valid in the same `p_tick` window. `hsync`/`vsync` need no extra delay stage.
- **Simultaneous wrap.** At x = 799, y = 524, one `p_tick` edge wraps both counters to (0,0) and returns `vsync` to 1 if it was low.

## Configuration
- **`VGA_SYNC_FRAME_CNT_EN` defined:** `frame_cnt` increments by 1 (mod 2^16) on every `frame_end` edge, and wraps 65535 → 0.
- **Undefined:** `frame_cnt` is tied to 16'h0000 and no counter register is synthesised.

## Test plan
- **Reset then release.**
  - During reset: x = 0, y = 0, hsync = 1, vsync = 1, video_on = 1, p_tick = 0.
  - After release: p_tick pulses at clks 4, 8, 12, … and x reads 1, 2, 3 after those edges.
- **Horizontal sweep.** Run one line:
  - video_on falls when x goes 639 → 640.
  - hsync = 0 for x = 656..751, i.e. 96 ticks.
  - line_end is high only in the x = 799 tick cycle; y increments 0 → 1.
- **Full frame.**
  - vsync = 0 for exactly 2 lines (y = 490, 491).
  - frame_end fires once, after 1,680,000 clks.
  - Counters return to (0,0); with the macro defined, frame_cnt = 1.
- **Mid-frame reset.** Assert `rst_n` = 0 at x = 700, y = 491 (hsync and vsync both low). Within the same cycle:
  - x = 0, y = 0, hsync = 1, vsync = 1.
  - Restart timing matches the reset test.
- **Macro off.** Run 3 frames: frame_cnt stays 0x0000 and all other outputs are identical to the macro-on build.
- **Parameter override.** With CLK_DIV = 2: p_tick every 2 clks and a line period of 1600 clks.

Source files
------------

// File: rtl/vga_sync.sv
// VGA raster timing generator: pixel-rate divider, x/y counters, registered syncs and strobes.
// Optional frame counter is built only when VGA_SYNC_FRAME_CNT_EN is defined.
module vga_sync #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        p_tick,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        line_end,
    output logic        frame_end,
    output logic [15:0] frame_cnt
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_MAX        = 10'(H_DISPLAY + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] H_DISP       = 10'(H_DISPLAY);
    localparam logic [9:0] H_SYNC_START = 10'(H_DISPLAY + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_DISPLAY + H_FP + H_SYNC - 1);

    localparam logic [9:0] V_MAX        = 10'(V_DISPLAY + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] V_DISP       = 10'(V_DISPLAY);
    localparam logic [9:0] V_SYNC_START = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;

    assign p_tick = (div_q == DIV_MAX);

    always_comb begin
        div_d = p_tick ? '0 : div_q + 1'b1;
        x_d   = x_q;
        y_d   = y_q;
        if (p_tick) begin
            if (x_q == H_MAX) begin
                x_d = '0;
                y_d = (y_q == V_MAX) ? 10'd0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
        // Syncs decode the next counter value so they stay aligned with x/y.
        hsync_d = !((x_d >= H_SYNC_START) && (x_d <= H_SYNC_END));
        vsync_d = !((y_d >= V_SYNC_START) && (y_d <= V_SYNC_END));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign video_on  = (x_q < H_DISP) && (y_q < V_DISP);
    assign line_end  = p_tick && (x_q == H_MAX);
    assign frame_end = line_end && (y_q == V_MAX);

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (frame_end) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a default instance and a shrunken-raster instance checked every cycle
// against an elapsed-time model, with randomized mid-frame resets.
module tb_vga_sync;

    localparam int DDIV = 4, DHD = 640, DHFP = 16, DHS = 96, DHBP = 48;
    localparam int DVD = 480, DVFP = 10, DVS = 2, DVBP = 33;
    localparam int DHT = DHD + DHFP + DHS + DHBP;

    localparam int SDIV = 2, SHD = 20, SHFP = 2, SHS = 4, SHBP = 4;
    localparam int SVD = 8, SVFP = 2, SVS = 2, SVBP = 3;
    localparam int SHT = SHD + SHFP + SHS + SHBP;
    localparam int SVT = SVD + SVFP + SVS + SVBP;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        d_pt, d_hs, d_vs, d_vo, d_le, d_fe;
    logic [9:0]  d_x, d_y;
    logic [15:0] d_fc;
    logic        s_pt, s_hs, s_vs, s_vo, s_le, s_fe;
    logic [9:0]  s_x, s_y;
    logic [15:0] s_fc;

    vga_sync u_def (
        .clk(clk), .rst_n(rst_n), .p_tick(d_pt), .x(d_x), .y(d_y), .hsync(d_hs),
        .vsync(d_vs), .video_on(d_vo), .line_end(d_le), .frame_end(d_fe), .frame_cnt(d_fc)
    );

    vga_sync #(
        .CLK_DIV(SDIV), .H_DISPLAY(SHD), .H_FP(SHFP), .H_SYNC(SHS), .H_BP(SHBP),
        .V_DISPLAY(SVD), .V_FP(SVFP), .V_SYNC(SVS), .V_BP(SVBP)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .p_tick(s_pt), .x(s_x), .y(s_y), .hsync(s_hs),
        .vsync(s_vs), .video_on(s_vo), .line_end(s_le), .frame_end(s_fe), .frame_cnt(s_fc)
    );

    int    checks = 0;
    int    errors = 0;
    longint n = 0;     // clk edges since the last reset release
    longint cyc = 0;
    bit    check_en = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected outputs purely from elapsed clocks: completed pixel ticks locate the raster point.
    task automatic model(input longint t, input int div, input int hd, input int hfp,
                         input int hs, input int hbp, input int vd, input int vfp,
                         input int vs, input int vbp,
                         output logic [9:0] ex, output logic [9:0] ey, output logic ept,
                         output logic ehs, output logic evs, output logic evo,
                         output logic ele, output logic efe, output logic [15:0] efc);
        longint ht, vt, ticks, pix;
        ht    = hd + hfp + hs + hbp;
        vt    = vd + vfp + vs + vbp;
        ticks = t / div;
        pix   = ticks % (ht * vt);
        ex    = 10'(pix % ht);
        ey    = 10'(pix / ht);
        ept   = (t % div) == (div - 1);
        ehs   = !((ex >= hd + hfp) && (ex < hd + hfp + hs));
        evs   = !((ey >= vd + vfp) && (ey < vd + vfp + vs));
        evo   = (ex < hd) && (ey < vd);
        ele   = ept && (ex == ht - 1);
        efe   = ele && (ey == vt - 1);
`ifdef VGA_SYNC_FRAME_CNT_EN
        efc   = 16'(ticks / (ht * vt));
`else
        efc   = 16'h0000;
`endif
    endtask

    task automatic check_dut(input string p, input int div, input int hd, input int hfp,
                             input int hs, input int hbp, input int vd, input int vfp,
                             input int vs, input int vbp,
                             input logic [9:0] gx, input logic [9:0] gy, input logic gpt,
                             input logic ghs, input logic gvs, input logic gvo, input logic gle,
                             input logic gfe, input logic [15:0] gfc);
        logic [9:0]  ex, ey;
        logic        ept, ehs, evs, evo, ele, efe;
        logic [15:0] efc;
        model(n, div, hd, hfp, hs, hbp, vd, vfp, vs, vbp,
              ex, ey, ept, ehs, evs, evo, ele, efe, efc);
        check_eq({p, ".x"}, gx, ex);
        check_eq({p, ".y"}, gy, ey);
        check_eq({p, ".p_tick"}, gpt, ept);
        check_eq({p, ".hsync"}, ghs, ehs);
        check_eq({p, ".vsync"}, gvs, evs);
        check_eq({p, ".video_on"}, gvo, evo);
        check_eq({p, ".line_end"}, gle, ele);
        check_eq({p, ".frame_end"}, gfe, efe);
        check_eq({p, ".frame_cnt"}, gfc, efc);
    endtask

    longint d_last_le = -1, s_last_le = -1, s_last_fe = -1, s_last_pt = -1;
    int     d_hs_cnt = 0;

    always @(negedge clk) begin
        if (check_en) begin
            check_dut("def", DDIV, DHD, DHFP, DHS, DHBP, DVD, DVFP, DVS, DVBP,
                      d_x, d_y, d_pt, d_hs, d_vs, d_vo, d_le, d_fe, d_fc);
            check_dut("sml", SDIV, SHD, SHFP, SHS, SHBP, SVD, SVFP, SVS, SVBP,
                      s_x, s_y, s_pt, s_hs, s_vs, s_vo, s_le, s_fe, s_fc);
            if (d_le) begin
                if (d_last_le >= 0) check_eq("def.line_period", 32'(cyc - d_last_le), DDIV * DHT);
                check_eq("def.hsync_low_ticks", d_hs_cnt, DHS);
                d_last_le = cyc;
                d_hs_cnt  = 0;
            end else if (d_pt && !d_hs) begin
                d_hs_cnt++;
            end
            if (s_pt) begin
                if (s_last_pt >= 0) check_eq("sml.tick_period", 32'(cyc - s_last_pt), SDIV);
                s_last_pt = cyc;
            end
            if (s_le) begin
                if (s_last_le >= 0) check_eq("sml.line_period", 32'(cyc - s_last_le), SDIV * SHT);
                s_last_le = cyc;
            end
            if (s_fe) begin
                if (s_last_fe >= 0)
                    check_eq("sml.frame_period", 32'(cyc - s_last_fe), SDIV * SHT * SVT);
                s_last_fe = cyc;
            end
        end
    end

    // Caller positions this just after a falling clk edge.
    task automatic do_reset(input int hold);
        #2 rst_n = 1'b0;
        #1;
        check_dut("def_rst", DDIV, DHD, DHFP, DHS, DHBP, DVD, DVFP, DVS, DVBP,
                  d_x, d_y, d_pt, d_hs, d_vs, d_vo, d_le, d_fe, d_fc);
        check_dut("sml_rst", SDIV, SHD, SHFP, SHS, SHBP, SVD, SVFP, SVS, SVBP,
                  s_x, s_y, s_pt, s_hs, s_vs, s_vo, s_le, s_fe, s_fc);
        check_eq("sml_rst.hsync_high", s_hs, 1'b1);
        check_eq("sml_rst.vsync_high", s_vs, 1'b1);
        d_last_le = -1;
        s_last_le = -1;
        s_last_fe = -1;
        s_last_pt = -1;
        d_hs_cnt  = 0;
        repeat (hold) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        bit found;
        check_en = 1'b1;
        repeat ($urandom_range(3, 6)) @(negedge clk);
        #2 rst_n = 1'b1;

        repeat (10000) @(negedge clk);

        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (!s_hs && !s_vs) found = 1'b1;
        end
        check_eq("sml.both_syncs_low_seen", found, 1'b1);
        do_reset($urandom_range(1, 5));

        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(500, 6000)) @(negedge clk);
            do_reset($urandom_range(1, 5));
        end

        repeat (8000) @(negedge clk);
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
